// File: rtl/multdiv_sequencer_if.sv
// Bundle between the execute stage, the shared ALU and the multiply/divide sequencer.
// The slave modport is the sequencer's view; the master modport is the pipeline/ALU side.
interface multdiv_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ctrl_MULT;
  logic                  ctrl_DIV;
  logic [DATA_WIDTH-1:0] data_operandA;
  logic [DATA_WIDTH-1:0] data_operandB;
  logic [DATA_WIDTH-1:0] alu_operandA;
  logic [DATA_WIDTH-1:0] alu_operandB;
  logic [4:0]            alu_opcode;
  logic [4:0]            alu_shiftamt;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] data_result;
  logic                  data_exception;
  logic                  data_resultRDY;
  logic                  busy;

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, alu_result,
    output alu_operandA, alu_operandB, alu_opcode, alu_shiftamt,
           data_result, data_exception, data_resultRDY, busy
  );

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, alu_result,
    input  alu_operandA, alu_operandB, alu_opcode, alu_shiftamt,
           data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Signed 32-bit shift-add multiply / restoring divide that borrows the execute ALU
// for one add or subtract per cycle.
//
// state  | meaning
// IDLE   | waiting for ctrl_MULT / ctrl_DIV, ALU driven with ADD 0,0
// ABS_A  | ALU forms |A|; a divide by zero short-circuits to DONE here
// ABS_B  | ALU forms |B|, partial register cleared, iteration counter loaded
// ITER   | 32 shift-add (mult) or shift-subtract (div) steps
// SIGN   | ALU applies the result sign; result and exception registered
// DONE   | one-cycle ready pulse; a new start may be accepted
module multdiv_sequencer #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [4:0] ALU_OP_ADD = 5'b00000,
  parameter logic [4:0] ALU_OP_SUB = 5'b00001
) (
  input logic            clock,
  input logic            ctrl_reset_n,
  multdiv_sequencer_if.slave bus
);
  localparam int MSB = DATA_WIDTH - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS_A,
    S_ABS_B,
    S_ITER,
    S_SIGN,
    S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [MSB:0] a_reg, b_reg, hi, lo, opd, result;
  logic [MSB:0] a_nxt, b_nxt, hi_nxt, lo_nxt, opd_nxt, result_nxt;
  logic         op_div, op_div_nxt, exc, exc_nxt;
  logic [4:0]   cnt, cnt_nxt;
  logic [MSB:0] alu_a, alu_b;
  logic [4:0]   alu_op;
  logic         start, neg, carry, borrow, mult_ovf;
  logic [MSB:0] rem_shift;

  assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
  assign neg       = a_reg[MSB] ^ b_reg[MSB];
  assign rem_shift = {hi[MSB-1:0], lo[MSB]};
  assign carry     = (hi[MSB] & opd[MSB]) | ((hi[MSB] | opd[MSB]) & ~bus.alu_result[MSB]);
  assign borrow    = (~rem_shift[MSB] & opd[MSB])
                   | ((~rem_shift[MSB] | opd[MSB]) & bus.alu_result[MSB]);
  // A negative product may reach exactly -2^31 without overflowing.
  assign mult_ovf  = ((hi != '0) | lo[MSB])
                   & ~(neg && (hi == '0) && (lo == {1'b1, {MSB{1'b0}}}));

  // ALU drive depends only on registered state, keeping the ALU path loop-free.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_OP_ADD;
    case (state)
      S_ABS_A: begin
        if (a_reg[MSB]) begin
          alu_b  = a_reg;
          alu_op = ALU_OP_SUB;
        end else begin
          alu_a = a_reg;
        end
      end
      S_ABS_B: begin
        if (b_reg[MSB]) begin
          alu_b  = b_reg;
          alu_op = ALU_OP_SUB;
        end else begin
          alu_a = b_reg;
        end
      end
      S_ITER: begin
        if (op_div) begin
          alu_a  = rem_shift;
          alu_b  = opd;
          alu_op = ALU_OP_SUB;
        end else if (lo[0]) begin
          alu_a = hi;
          alu_b = opd;
        end
      end
      S_SIGN: begin
        if (neg) begin
          alu_b  = lo;
          alu_op = ALU_OP_SUB;
        end else begin
          alu_a = lo;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    a_nxt      = a_reg;
    b_nxt      = b_reg;
    hi_nxt     = hi;
    lo_nxt     = lo;
    opd_nxt    = opd;
    op_div_nxt = op_div;
    cnt_nxt    = cnt;
    result_nxt = result;
    exc_nxt    = exc;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_nxt      = bus.data_operandA;
          b_nxt      = bus.data_operandB;
          op_div_nxt = ~bus.ctrl_MULT;
          result_nxt = '0;
          exc_nxt    = 1'b0;
          state_nxt  = S_ABS_A;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_ABS_A: begin
        if (op_div && (b_reg == '0)) begin
          result_nxt = '0;
          exc_nxt    = 1'b1;
          state_nxt  = S_DONE;
        end else begin
          if (op_div) lo_nxt = bus.alu_result;
          else        opd_nxt = bus.alu_result;
          state_nxt = S_ABS_B;
        end
      end
      S_ABS_B: begin
        if (op_div) opd_nxt = bus.alu_result;
        else        lo_nxt  = bus.alu_result;
        hi_nxt    = '0;
        cnt_nxt   = 5'd31;
        state_nxt = S_ITER;
      end
      S_ITER: begin
        if (op_div) begin
          hi_nxt = borrow ? rem_shift : bus.alu_result;
          lo_nxt = {lo[MSB-1:0], ~borrow};
        end else if (lo[0]) begin
          hi_nxt = {carry, bus.alu_result[MSB:1]};
          lo_nxt = {bus.alu_result[0], lo[MSB:1]};
        end else begin
          hi_nxt = {1'b0, hi[MSB:1]};
          lo_nxt = {hi[0], lo[MSB:1]};
        end
        cnt_nxt = cnt - 5'd1;
        if (cnt == 5'd0) state_nxt = S_SIGN;
      end
      S_SIGN: begin
        result_nxt = bus.alu_result;
        exc_nxt    = op_div ? (~neg & lo[MSB]) : mult_ovf;
        state_nxt  = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      state  <= S_IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      hi     <= '0;
      lo     <= '0;
      opd    <= '0;
      op_div <= 1'b0;
      cnt    <= '0;
      result <= '0;
      exc    <= 1'b0;
    end else begin
      state  <= state_nxt;
      a_reg  <= a_nxt;
      b_reg  <= b_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
      opd    <= opd_nxt;
      op_div <= op_div_nxt;
      cnt    <= cnt_nxt;
      result <= result_nxt;
      exc    <= exc_nxt;
    end
  end

  assign bus.alu_operandA   = alu_a;
  assign bus.alu_operandB   = alu_b;
  assign bus.alu_opcode     = alu_op;
  assign bus.alu_shiftamt   = 5'd0;
  assign bus.data_result    = result;
  assign bus.data_exception = exc;
  assign bus.data_resultRDY = (state == S_DONE);
  assign bus.busy           = (state != S_IDLE);
endmodule
